recip_arbiter: RTL and testbench
================================

# recip_arbiter

Shares one reciprocal (Newton-iteration divider) unit among `N_REQ` requesters in the HLL kernel. Collects 32-bit divisor requests over valid/ready handshakes and picks one round-robin. Drives the divider's single-pulse input, waits for its result pulse, and returns the 48-bit result tagged with the requester index. Only one operation is in flight at any time, because a new input pulse restarts the divider. A zero divisor is answered locally, and a watchdog covers a divider that never responds.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `ID_W`, `$clog2(N_REQ)`: width of the requester tag.
- `TIMEOUT`, 64: WAIT cycles allowed before an error response; must be greater than the divider latency.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester request valid.
- `req_ready` out N_REQ: per-requester grant; one-hot or zero.
- `req_data` in N_REQ*32: flattened divisors; requester i occupies bits [32i+31:32i].
- `div_in_data` out 32: divisor to the divider.
- `div_in_valid` out 1: one-cycle start pulse to the divider.
- `div_out_valid` in 1: divider result pulse.
- `div_out_value` in 48: divider result.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out ID_W: index of the requester being answered.
- `rsp_value` out 48: the result.
- `rsp_err` out 1: 1 = zero divisor or timeout.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States and transitions:
  - IDLE: on any `req_valid`, go to ISSUE with the winner latched.
  - ISSUE: for a nonzero divisor, go to WAIT. For a zero divisor, go to RESP with `rsp_value`=48'hFFFF_FFFF_FFFF and `rsp_err`=1; no pulse is issued.
  - WAIT: on `div_out_valid`, go to RESP. When the timer equals TIMEOUT-1, go to RESP with the all-ones value and `rsp_err`=1.
  - RESP: on `rsp_ready`, go to IDLE.
- Arbitration:
  - Round-robin, starting from pointer `rr`.
  - Winner = first i in `rr`, `rr`+1, … (mod N_REQ) with `req_valid[i]`=1.
  - `req_ready[winner]` is combinational and asserted only in IDLE. The handshake completes in that same cycle, and `id` and `data` are latched.
  - `rr` becomes winner+1 (mod N_REQ) when RESP completes, not at grant.
- Issue:
  - In ISSUE, `div_in_valid`=1 for exactly one cycle and `div_in_data` = the latched divisor.
  - `div_in_data` holds its value until the next grant.
  - The WAIT timer clears on entry to WAIT and increments each WAIT cycle.
- Capture:
  - `div_out_value` is sampled only in the WAIT cycle where `div_out_valid`=1.
  - `div_out_valid` in any other state is ignored. The divider has no reset, so stray pulses after `rst_n` must not produce a response.
- Response:
  - `rsp_valid`, `rsp_id`, `rsp_value` and `rsp_err` are registered.
  - They are stable while `rsp_valid`=1 and `rsp_ready`=0.
- Zero divisor: decided in ISSUE by a 32-bit compare with 0.
- Error precedence: if `div_out_valid` and timeout coincide in the same cycle, the result wins and `rsp_err`=0.

## Timing
- Reset values:
  - state IDLE, `rr`=0, timer=0.
  - `req_ready`=0 (IDLE with no `req_valid`).
  - `div_in_valid`=0, `div_in_data`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_value`=0, `rsp_err`=0, `busy`=0.
- Reset during WAIT or RESP: the operation is dropped and no response is produced. The requester already saw its handshake and must tolerate the loss.
- Cycle sequence for a nonzero divisor:
  - T0: grant.
  - T1: `div_in_valid`.
  - Tk: divider returns `div_out_valid`.
  - Tk+1: `rsp_valid`.
  - Next grant no earlier than the cycle after `rsp_ready`.
- Zero divisor: grant at T0, `rsp_valid` at T2.
- Timeout: `rsp_valid` at T1+TIMEOUT+1.
- Throughput with a divider of latency L: one result per L+3 cycles minimum.
- Simultaneous requests: exactly one `req_ready` bit per grant. Losers keep `req_valid` asserted with data stable.
- A requester dropping `req_valid` without a handshake is legal and gets no grant.

## Test plan
The bench uses a divider stub: after a `div_in_valid` pulse it returns `div_out_valid` 10 cycles later with `div_out_value` = {16'h0, data}.

- Single request: requester 2 sends 32'h0000_0010 → grant at T0, `div_in_valid` at T1, `rsp_valid` at T12 with id 2, value 48'h0000_0000_0010, err 0.
- Fairness: all 4 requesters valid continuously with `rsp_ready`=1 → grant order 0,1,2,3,0, each response tagged correctly, one operation in flight.
- Zero divisor: requester 1 sends 0 → no `div_in_valid`, response at T2 with value 48'hFFFF_FFFF_FFFF, err 1.
- Timeout: stub suppressed, TIMEOUT=64 → error response at T66, all-ones value. The next request is then served normally.
- Backpressure: `rsp_ready` held low for 20 cycles → response fields stable, no new grant, `busy`=1. Release completes the handshake and `rr` advances.
- Reset/stray: `rst_n` pulsed low mid-WAIT, then the stub fires → no response, outputs at reset values. A stray `div_out_valid` in IDLE is ignored.

Source files
------------

// File: rtl/recip_arbiter_if.sv
// rtl/recip_arbiter_if.sv - request, divider and response signals of recip_arbiter
//
// Purpose: bundles the requester, divider and response signals of recip_arbiter.
// Ports (slave = arbiter side):
//   req_valid/req_ready/req_data     : N_REQ requesters, 32-bit divisors, flattened
//   div_in_valid/div_in_data         : start pulse and divisor to the divider
//   div_out_valid/div_out_value      : result pulse and 48-bit result from the divider
//   rsp_valid/rsp_ready/rsp_id/rsp_value/rsp_err : tagged response
//   busy                             : arbiter not idle
interface recip_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*32-1:0] req_data;
    logic [31:0]         div_in_data;
    logic                div_in_valid;
    logic                div_out_valid;
    logic [47:0]         div_out_value;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [47:0]         rsp_value;
    logic                rsp_err;
    logic                busy;

    modport master (
        output req_valid, req_data, div_out_valid, div_out_value, rsp_ready,
        input  req_ready, div_in_data, div_in_valid, rsp_valid, rsp_id,
               rsp_value, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_data, div_out_valid, div_out_value, rsp_ready,
        output req_ready, div_in_data, div_in_valid, rsp_valid, rsp_id,
               rsp_value, rsp_err, busy
    );
endinterface

// File: rtl/recip_arbiter.sv
// rtl/recip_arbiter.sv - round-robin sharing of one reciprocal unit among N_REQ requesters
//
// Purpose: grants one requester at a time (round-robin), issues its divisor to the
// divider as a single pulse, waits for the result (with a watchdog) and returns it
// tagged with the requester index. Zero divisors are answered locally with an error.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : recip_arbiter_if.slave (requests, divider, response, busy)
module recip_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    recip_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Timer only ever needs to reach TIMEOUT-1.
    localparam int              TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
    localparam int              CW     = ID_W + 1;
    localparam logic [47:0]     ALL1   = 48'hFFFF_FFFF_FFFF;

    logic [1:0]      state;
    logic [ID_W-1:0] rr;
    logic [ID_W-1:0] id_q;
    logic [31:0]     data_q;
    logic [TW-1:0]   timer;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [47:0]     rsp_value_q;
    logic            rsp_err_q;

    // Round-robin search: first valid requester at or after rr, wrapping mod N_REQ.
    // cand carries one extra bit so rr+k never overflows before the wrap.
    logic            found;
    logic [ID_W-1:0] win;
    logic [CW-1:0]   cand;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr} + CW'(k);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                win   = cand[ID_W-1:0];
            end
        end
    end

    logic [31:0] win_data;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) begin
                win_data = bus.req_data[i*32 +: 32];
            end
        end
    end

    // Pointer moves past the served requester only once its response is taken.
    logic [CW-1:0]   inc;
    logic [ID_W-1:0] rr_next;

    always_comb begin
        inc     = {1'b0, id_q} + CW'(1);
        rr_next = (inc >= CW'(N_REQ)) ? '0 : inc[ID_W-1:0];
    end

    logic grant;
    assign grant = (state == S_IDLE) && found;

    always_comb begin
        bus.req_ready = '0;
        if (grant) begin
            bus.req_ready[win] = 1'b1;
        end
    end

    // ISSUE lasts exactly one cycle, so the pulse is one cycle wide.
    assign bus.div_in_valid = (state == S_ISSUE) && (data_q != 32'd0);
    assign bus.div_in_data  = data_q;
    assign bus.busy         = (state != S_IDLE);
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_value    = rsp_value_q;
    assign bus.rsp_err      = rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rr          <= '0;
            id_q        <= '0;
            data_q      <= '0;
            timer       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_value_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        id_q   <= win;
                        data_q <= win_data;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (data_q == 32'd0) begin
                        state       <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_value_q <= ALL1;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                        timer <= '0;
                    end
                end
                S_WAIT: begin
                    // A result arriving on the timeout cycle still counts as success.
                    if (bus.div_out_valid) begin
                        state       <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_value_q <= bus.div_out_value;
                        rsp_err_q   <= 1'b0;
                    end else if (timer == T_LAST) begin
                        state       <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_value_q <= ALL1;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr          <= rr_next;
                        state       <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_recip_arbiter.sv
// tb/tb_recip_arbiter.sv - scoreboard testbench for recip_arbiter
module tb_recip_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 64;
    localparam int LAT = 10;

    localparam int M_DIR  = 0;
    localparam int M_FAIR = 1;
    localparam int M_RAND = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    recip_arbiter_if #(.N_REQ(N), .ID_W(IDW)) bus ();

    recip_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [47:0] value;
        logic        err;
        int          lat;
        int          gcyc;
        bit          pulse_exp;
        bit          pulsed;
        bit          seen;
    } exp_t;

    exp_t        sbq[$];
    int          grants[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          model_rr = 0;
    int          free_at = 0;
    int          mode = M_DIR;
    bit          suppress = 1'b0;
    bit          stray = 1'b0;
    int          fire_at = -100;
    logic [31:0] stub_data = 32'd0;
    logic [N-1:0] hs_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Divider stub: result LAT cycles after the start pulse, value = {16'h0, divisor}.
    always @(negedge clk) begin
        if (bus.div_in_valid === 1'b1) begin
            fire_at   = cyc + LAT;
            stub_data = bus.div_in_data;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        bus.div_out_valid = stray || (!suppress && cyc == fire_at);
        bus.div_out_value = {16'h0, stub_data};
    end

    // Monitor: checks divider pulses and responses against the scoreboard front.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.div_in_valid) begin
                if (sbq.size() == 0) begin
                    chk("pulse_unexpected", 64'(bus.div_in_valid), 64'd0);
                end else begin
                    chk("pulse_allowed", 64'(sbq[0].pulse_exp && !sbq[0].pulsed), 64'd1);
                    chk("pulse_cycle", 64'(cyc - sbq[0].gcyc), 64'd1);
                    chk("div_in_data", 64'(bus.div_in_data), 64'(sbq[0].data));
                    sbq[0].pulsed = 1'b1;
                end
            end
            if (bus.rsp_valid) begin
                if (sbq.size() == 0) begin
                    chk("rsp_spurious", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    if (!sbq[0].seen) begin
                        chk("rsp_latency", 64'(cyc - sbq[0].gcyc), 64'(sbq[0].lat));
                        sbq[0].seen = 1'b1;
                    end
                    chk("rsp_id", 64'(bus.rsp_id), 64'(sbq[0].id));
                    chk("rsp_value", 64'(bus.rsp_value), 64'(sbq[0].value));
                    chk("rsp_err", 64'(bus.rsp_err), 64'(sbq[0].err));
                    chk("busy_in_rsp", 64'(bus.busy), 64'd1);
                    if (bus.rsp_ready) begin
                        chk("pulse_count", 64'(sbq[0].pulsed), 64'(sbq[0].pulse_exp));
                        model_rr = (sbq[0].id + 1) % N;
                        free_at  = cyc + 1;
                        void'(sbq.pop_front());
                    end
                end
            end
        end
    end

    // Grant check against the round-robin rule and push of the expected response.
    task automatic check_grant();
        logic [N-1:0] expv;
        int w;
        exp_t e;
        expv = '0;
        w = -1;
        if (sbq.size() == 0 && cyc >= free_at) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (model_rr + k) % N;
                if (w < 0 && bus.req_valid[idx]) w = idx;
            end
            if (w >= 0) expv[w] = 1'b1;
        end
        chk("req_ready", 64'(bus.req_ready), 64'(expv));
        hs_last = bus.req_ready & bus.req_valid;
        for (int i = 0; i < N; i++) begin
            if (hs_last[i]) begin
                e.id     = i;
                e.data   = bus.req_data[i*32 +: 32];
                e.gcyc   = cyc;
                e.pulsed = 1'b0;
                e.seen   = 1'b0;
                if (e.data == 32'd0) begin
                    e.value = 48'hFFFF_FFFF_FFFF; e.err = 1'b1; e.lat = 2; e.pulse_exp = 1'b0;
                end else if (suppress) begin
                    e.value = 48'hFFFF_FFFF_FFFF; e.err = 1'b1; e.lat = TO + 2; e.pulse_exp = 1'b1;
                end else begin
                    e.value = {16'h0, e.data}; e.err = 1'b0; e.lat = LAT + 2; e.pulse_exp = 1'b1;
                end
                sbq.push_back(e);
                grants.push_back(i);
            end
        end
    endtask

    function automatic logic [31:0] rand_data();
        return ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    endfunction

    task automatic step();
        @(negedge clk);
        check_grant();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_last[i]) begin
                if (mode == M_DIR) begin
                    bus.req_valid[i] = 1'b0;
                end else if (mode == M_FAIR) begin
                    bus.req_data[i*32 +: 32] = $urandom | 32'd1;
                end else begin
                    bus.req_valid[i] = 1'($urandom_range(0, 1));
                    bus.req_data[i*32 +: 32] = rand_data();
                end
            end else if (mode == M_RAND) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_data[i*32 +: 32] = rand_data();
                end else if (bus.req_valid[i] && $urandom_range(0, 15) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
        if (mode == M_RAND) bus.rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sbq.size() != 0 || bus.req_valid != '0) && n < budget) begin
            step();
            n++;
        end
        chk("drain", 64'(sbq.size()), 64'd0);
    endtask

    task automatic request(input int i, input logic [31:0] d);
        bus.req_data[i*32 +: 32] = d;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        chk({tag, "_div_in_valid"}, 64'(bus.div_in_valid), 64'd0);
        chk({tag, "_div_in_data"}, 64'(bus.div_in_data), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'd0);
        chk({tag, "_rsp_value"}, 64'(bus.rsp_value), 64'd0);
        chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req_valid     = '0;
        bus.req_data      = '0;
        bus.rsp_ready     = 1'b0;
        bus.div_out_valid = 1'b0;
        bus.div_out_value = '0;
        hs_last           = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;

        // Single request from requester 2.
        request(2, 32'h0000_0010);
        drain(100);

        // Zero divisor from requester 1.
        request(1, 32'h0);
        drain(100);

        // Divider never answers, then a normal request.
        suppress = 1'b1;
        request(3, 32'h0000_1234);
        drain(200);
        suppress = 1'b0;
        request(0, 32'h0000_0055);
        drain(100);

        // Backpressure: response held for well over 20 cycles with others waiting.
        bus.rsp_ready = 1'b0;
        request(1, 32'h0000_0077);
        request(0, 32'h0000_0100);
        request(2, 32'h0000_0200);
        repeat (40) step();
        bus.rsp_ready = 1'b1;
        drain(200);

        // Reset in the middle of WAIT; the pending stub result must be ignored.
        request(3, 32'h0000_0099);
        repeat (6) step();
        rst_n = 1'b0;
        sbq.delete();
        free_at  = 0;
        model_rr = 0;
        repeat (2) step();
        @(negedge clk);
        check_reset_outputs("mid_wait_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) step();
        @(negedge clk);
        check_reset_outputs("after_stray_result");

        // Stray divider pulse in IDLE.
        @(posedge clk);
        #1;
        stray = 1'b1;
        step();
        stray = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("stray_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("stray_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;

        // Fairness from reset pointer: all four requesters continuously valid.
        grants.delete();
        mode = M_FAIR;
        for (int i = 0; i < N; i++) request(i, $urandom | 32'd1);
        n = 0;
        while (grants.size() < 8 && n < 300) begin
            step();
            n++;
        end
        chk("fair_grant_count", 64'(grants.size() >= 8), 64'd1);
        if (grants.size() >= 5) begin
            chk("fair_order0", 64'(grants[0]), 64'd0);
            chk("fair_order1", 64'(grants[1]), 64'd1);
            chk("fair_order2", 64'(grants[2]), 64'd2);
            chk("fair_order3", 64'(grants[3]), 64'd3);
            chk("fair_order4", 64'(grants[4]), 64'd0);
        end
        bus.req_valid = '0;
        mode = M_DIR;
        drain(100);

        // Randomized traffic, then a shorter run with the divider silent.
        mode = M_RAND;
        repeat (3000) step();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        mode = M_DIR;
        drain(300);

        suppress = 1'b1;
        mode = M_RAND;
        repeat (400) step();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        mode = M_DIR;
        drain(300);
        suppress = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
